// File: rtl/regfile_scb_if.sv
// Register-file bus: two read ports with busy status, a byte-masked writeback port,
// and the issue port that reserves a destination register.
interface regfile_scb_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic [ADDR_W-1:0]   ReadReg1;
  logic [ADDR_W-1:0]   ReadReg2;
  logic [DATA_W-1:0]   ReadData1;
  logic [DATA_W-1:0]   ReadData2;
  logic                Busy1;
  logic                Busy2;
  logic                WE;
  logic [ADDR_W-1:0]   WriteReg;
  logic [DATA_W-1:0]   WriteData;
  logic [DATA_W/8-1:0] ByteEn;
  logic                Issue;
  logic [ADDR_W-1:0]   IssueReg;
  logic                IssueWAW;
  logic [ADDR_W:0]     BusyCount;

  modport master (
    output ReadReg1, ReadReg2, WE, WriteReg, WriteData, ByteEn, Issue, IssueReg,
    input  ReadData1, ReadData2, Busy1, Busy2, IssueWAW, BusyCount
  );

  modport slave (
    input  ReadReg1, ReadReg2, WE, WriteReg, WriteData, ByteEn, Issue, IssueReg,
    output ReadData1, ReadData2, Busy1, Busy2, IssueWAW, BusyCount
  );
endinterface

// File: rtl/regfile_scb.sv
// Register file with a per-register busy scoreboard: combinational reads, byte-masked
// writeback that releases the busy bit, and issue-time reservation.
module regfile_scb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input logic           CLK,
  input logic           clrn,
  regfile_scb_if.slave  bus
);
  localparam int Depth = 2 ** ADDR_W;
  localparam int Lanes = DATA_W / 8;

  logic [DATA_W-1:0] regs_q [Depth];
  logic [Depth-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              wr_ok, iss_ok, inc, dec;
  logic [DATA_W-1:0] merged, rdata1, rdata2;

  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return !(ZERO_REG != 0 && a == '0);
  endfunction

  assign wr_ok  = bus.WE && writable(bus.WriteReg);
  assign iss_ok = bus.Issue && writable(bus.IssueReg);

  always_comb begin
    merged = regs_q[bus.WriteReg];
    for (int i = 0; i < Lanes; i++) begin
      if (bus.ByteEn[i]) merged[8*i +: 8] = bus.WriteData[8*i +: 8];
    end
  end

  always_comb begin
    rdata1 = regs_q[bus.ReadReg1];
    rdata2 = regs_q[bus.ReadReg2];
    if (BYPASS != 0 && wr_ok && bus.WriteReg == bus.ReadReg1) rdata1 = merged;
    if (BYPASS != 0 && wr_ok && bus.WriteReg == bus.ReadReg2) rdata2 = merged;
    if (!writable(bus.ReadReg1)) rdata1 = '0;
    if (!writable(bus.ReadReg2)) rdata2 = '0;
  end

  assign bus.ReadData1 = rdata1;
  assign bus.ReadData2 = rdata2;
  assign bus.Busy1 = busy_q[bus.ReadReg1] && writable(bus.ReadReg1) &&
                     !(BYPASS != 0 && bus.WE && bus.WriteReg == bus.ReadReg1);
  assign bus.Busy2 = busy_q[bus.ReadReg2] && writable(bus.ReadReg2) &&
                     !(BYPASS != 0 && bus.WE && bus.WriteReg == bus.ReadReg2);
  assign bus.IssueWAW = bus.Issue && busy_q[bus.IssueReg] &&
                        !(bus.WE && bus.WriteReg == bus.IssueReg);
  assign bus.BusyCount = count_q;

  // Set wins over clear on the same register, so a same-register pair only counts the set.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok)  busy_d[bus.WriteReg] = 1'b0;
    if (iss_ok) busy_d[bus.IssueReg] = 1'b1;
    inc = iss_ok && !busy_q[bus.IssueReg];
    dec = wr_ok && busy_q[bus.WriteReg] && !(iss_ok && bus.IssueReg == bus.WriteReg);
    count_d = count_q + (ADDR_W + 1)'(inc) - (ADDR_W + 1)'(dec);
  end

  always_ff @(posedge CLK or negedge clrn) begin
    if (!clrn) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge CLK or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < Depth; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[bus.WriteReg] <= merged;
    end
  end
endmodule
